// File: rtl/mux.sv
// N-lane, W-bit multiplexer with out-of-range flag and a registered select-change pulse.
// Define MUX_OUT_REG_EN to register out and sel_err (one cycle of latency, reset to 0).
module mux #(
  parameter  int N     = 4,
  parameter  int W     = 1,
  localparam int SEL_W = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic [N*W-1:0]   in,
  input  logic [SEL_W-1:0] select,
  output logic [W-1:0]     out,
  input  logic             clk,
  input  logic             rst_n,
  output logic             sel_err,
  output logic             sel_changed
);

  logic [W-1:0]     lane [N];
  logic [N-1:0]     hit;
  logic [W-1:0]     mux_val;
  logic             sel_err_next;
  logic [SEL_W-1:0] prev_sel_reg;
  logic             sel_changed_reg;

  // One decoded hit per lane; an index with no hit is out of range.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lane[gi] = in[gi*W +: W];
      assign hit[gi]  = (select == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    mux_val = '0;
    for (int i = 0; i < N; i++) begin
      mux_val = mux_val | (lane[i] & {W{hit[i]}});
    end
    sel_err_next = ~(|hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sel_reg    <= '0;
      sel_changed_reg <= 1'b0;
    end else begin
      prev_sel_reg    <= select;
      sel_changed_reg <= (select != prev_sel_reg);
    end
  end

  assign sel_changed = sel_changed_reg;

`ifdef MUX_OUT_REG_EN
  logic [W-1:0] out_reg;
  logic         sel_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg     <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      out_reg     <= mux_val;
      sel_err_reg <= sel_err_next;
    end
  end

  assign out     = out_reg;
  assign sel_err = sel_err_reg;
`else
  assign out     = mux_val;
  assign sel_err = sel_err_next;
`endif

endmodule

// File: tb/tb_mux.sv
// Directed bench for mux (default build): a 4x1 and a 5x8 instance checked
// through an expected-value queue that is filled at drive time and drained at sampling time.
module tb_mux;
  localparam int N4 = 4;
  localparam int W4 = 1;
  localparam int N5 = 5;
  localparam int W5 = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N4*W4-1:0]  in4;
  logic [1:0]        sel4;
  logic [W4-1:0]     out4;
  logic              err4;
  logic              chg4;
  logic [N5*W5-1:0]  in5;
  logic [2:0]        sel5;
  logic [W5-1:0]     out5;
  logic              err5;
  logic              chg5;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [1:0]  model_prev4;
  logic [2:0]  model_prev5;

  always #5 clk = ~clk;

  mux #(.N(N4), .W(W4)) dut4 (
    .in(in4), .select(sel4), .out(out4), .clk(clk), .rst_n(rst_n),
    .sel_err(err4), .sel_changed(chg4)
  );

  mux #(.N(N5), .W(W5)) dut5 (
    .in(in5), .select(sel5), .out(out5), .clk(clk), .rst_n(rst_n),
    .sel_err(err5), .sel_changed(chg5)
  );

  task automatic push(input string tag, input logic [31:0] e);
    exp_t t;
    t.tag = tag;
    t.exp = e;
    sb.push_back(t);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    exp_t t;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
    end else begin
      t = sb.pop_front();
      assert (obs === t.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", t.tag, obs, t.exp);
      end
    end
  endtask

  function automatic logic [31:0] lane4(input logic [1:0] s);
    if (int'(s) < N4) return 32'(in4[s]);
    return 32'd0;
  endfunction

  function automatic logic [31:0] lane5(input logic [2:0] s);
    if (int'(s) < N5) return 32'(in5[int'(s)*W5 +: W5]);
    return 32'd0;
  endfunction

  task automatic step4(input logic [1:0] s);
    @(negedge clk);
    sel4 = s;
    push("out4", lane4(s));
    push("err4", 32'(int'(s) >= N4));
    push("chg4", 32'(s != model_prev4));
    model_prev4 = s;
    #1;
    check("out4", 32'(out4));
    check("err4", 32'(err4));
    @(posedge clk);
    #1;
    check("chg4", 32'(chg4));
    $display("step4 sel=%0d out=%0h err=%0b chg=%0b", s, out4, err4, chg4);
  endtask

  task automatic step5(input logic [2:0] s);
    @(negedge clk);
    sel5 = s;
    push("out5", lane5(s));
    push("err5", 32'(int'(s) >= N5));
    push("chg5", 32'(s != model_prev5));
    model_prev5 = s;
    #1;
    check("out5", 32'(out5));
    check("err5", 32'(err5));
    @(posedge clk);
    #1;
    check("chg5", 32'(chg5));
    $display("step5 sel=%0d out=%0h err=%0b chg=%0b", s, out5, err5, chg5);
  endtask

  initial begin
    rst_n = 1'b0;
    in4   = 4'b1001;
    sel4  = 2'd2;
    in5   = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    sel5  = 3'd0;
    model_prev4 = '0;
    model_prev5 = '0;

    // Reset state, and the mux keeps tracking select while in reset.
    #1;
    push("rst_out4", 32'd0); check("rst_out4", 32'(out4));
    push("rst_err4", 32'd0); check("rst_err4", 32'(err4));
    push("rst_chg4", 32'd0); check("rst_chg4", 32'(chg4));
    push("rst_chg5", 32'd0); check("rst_chg5", 32'(chg5));
    #2;
    sel4 = 2'd3;
    #1;
    push("rst_track4", 32'd1); check("rst_track4", 32'(out4));
    @(posedge clk);
    #1;
    push("rst_hold_chg4", 32'd0); check("rst_hold_chg4", 32'(chg4));

    @(negedge clk);
    rst_n = 1'b1;
    sel4  = 2'd0;
    @(posedge clk);
    #1;
    push("first_zero_chg4", 32'd0); check("first_zero_chg4", 32'(chg4));

    // Change-detect sequence, then a full sweep (pulse held high on every change).
    step4(2'd0); step4(2'd0); step4(2'd2); step4(2'd2); step4(2'd3);
    step4(2'd0); step4(2'd1); step4(2'd2); step4(2'd3);
    step4(2'd3); step4(2'd3);

    // Data change with select held: output follows without a clock edge.
    @(negedge clk);
    in4 = 4'b0110;
    push("in_change_out4", lane4(sel4));
    #1;
    check("in_change_out4", 32'(out4));
    in4 = 4'b1001;
    #1;
    push("in_restore_out4", 32'd1); check("in_restore_out4", 32'(out4));

    // Wide lanes, including out-of-range indices.
    step5(3'd4); step5(3'd5); step5(3'd6); step5(3'd7); step5(3'd3); step5(3'd0);

    // Asynchronous reset while sel_changed is high.
    step4(2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_chg4", 32'd0); check("async_chg4", 32'(chg4));
    sel4 = 2'd0;
    #1;
    push("async_track4", 32'd1); check("async_track4", 32'(out4));
    sel4 = 2'd2;
    @(posedge clk);
    #1;
    push("async_hold_chg4", 32'd0); check("async_hold_chg4", 32'(chg4));

    // First edge after release compares against zero.
    @(negedge clk);
    rst_n = 1'b1;
    sel4  = 2'd3;
    model_prev4 = 2'd3;
    @(posedge clk);
    #1;
    push("first_edge_chg4", 32'd1); check("first_edge_chg4", 32'(chg4));
    step4(2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
